gpu_hw_regs_read_port: RTL and testbench

Host-side read responder for the GPU hardware control register bank. Accepts read requests on a 20-bit host address with a valid/ready handshake. Decodes the register window and samples the addressed byte from the bank's parallel register outputs. Returns responses in request order through a small response FIFO with back-pressure, forming the read half of the path whose write half is `GPU_HW_Control_Regs`.

---
 rtl/gpu_hw_regs_read_port_pkg.sv | 23 ++
 rtl/gpu_hw_regs_read_port_if.sv | 24 ++
 rtl/gpu_hw_regs_read_port_fifo.sv | 67 ++++++
 rtl/gpu_hw_regs_read_port.sv | 95 +++++++++
 tb/tb_gpu_hw_regs_read_port.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/gpu_hw_regs_read_port_pkg.sv
// Shared types and constants for the GPU hardware register read path.
package gpu_hw_regs_pkg;

    localparam int HW_REGS_SIZE_DEF = 8;
    localparam int ADDR_W           = 20;
    localparam logic [7:0] MISS_DATA = 8'hFF;

    typedef struct packed {
        logic [7:0]        data;
        logic              hit;
        logic [ADDR_W-1:0] addr;
    } hw_reg_rsp_t;

    // True when addr falls in the window at base; the low sz bits are the register index.
    function automatic logic win_hit(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input int unsigned       sz);
        logic [ADDR_W-1:0] mask;
        mask = {ADDR_W{1'b1}} << sz;
        return ((addr ^ base) & mask) == {ADDR_W{1'b0}};
    endfunction

endpackage

// File: rtl/gpu_hw_regs_read_port_if.sv
// Host request / response bundle of the register read port.
interface gpu_hw_regs_read_port_if;
    import gpu_hw_regs_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_data;
    logic              rsp_hit;
    logic [ADDR_W-1:0] rsp_addr;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, rsp_addr
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_hit, rsp_addr
    );

endinterface

// File: rtl/gpu_hw_regs_read_port_fifo.sv
// Synchronous response FIFO with a registered head entry.
module hw_regs_rsp_fifo
    import gpu_hw_regs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  hw_reg_rsp_t              push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output hw_reg_rsp_t              head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    hw_reg_rsp_t   mem_r [DEPTH];
    hw_reg_rsp_t   head_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] rd_nxt_s;
    logic [CW-1:0] count_r;
    logic          pop_s;

    assign pop_s    = pop && (count_r != '0);
    assign rd_nxt_s = rd_ptr_r + PW'(1);
    assign count    = count_r;
    assign head     = head_r;

    // Entry storage; never overflows because the producer is credit limited.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and the head register that drives the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_nxt_s;
            end
            case ({push, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            // Next head comes from storage if more entries wait, else straight from the push.
            if (pop_s && (count_r > CW'(1))) begin
                head_r <= mem_r[rd_nxt_s];
            end else if (push && ((count_r == '0) || pop_s)) begin
                head_r <= push_data;
            end
        end
    end

endmodule

// File: rtl/gpu_hw_regs_read_port.sv
// Host-side read responder: capture, window decode, bank sample and in-order response queue.
module gpu_hw_regs_read_port
    import gpu_hw_regs_pkg::*;
#(
    parameter int                HW_REGS_SIZE = HW_REGS_SIZE_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDRESS = 20'h0,
    parameter int                FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [(2**HW_REGS_SIZE)-1:0][7:0]  regs,
    gpu_hw_regs_read_port_if.slave             bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                    cap_vld_r;
    logic [ADDR_W-1:0]       cap_addr_r;
    logic                    a_vld_r;
    logic                    a_hit_r;
    logic [HW_REGS_SIZE-1:0] a_idx_r;
    logic [ADDR_W-1:0]       a_addr_r;
    logic [CW-1:0]           cred_r;
    logic [CW-1:0]           fifo_count_s;
    logic                    accept_s;
    logic                    pop_s;
    hw_reg_rsp_t             push_data_s;
    hw_reg_rsp_t             head_s;

    assign bus.req_ready = !rst && (cred_r < CW'(FIFO_DEPTH));
    assign accept_s      = bus.req_valid && bus.req_ready;
    assign pop_s         = bus.rsp_valid && bus.rsp_ready;

    // Request capture followed by window decode (stage A).
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_r  <= 1'b0;
            cap_addr_r <= '0;
            a_vld_r    <= 1'b0;
            a_hit_r    <= 1'b0;
            a_idx_r    <= '0;
            a_addr_r   <= '0;
        end else begin
            cap_vld_r  <= accept_s;
            cap_addr_r <= bus.req_addr;
            a_vld_r    <= cap_vld_r;
            a_hit_r    <= win_hit(cap_addr_r, BASE_ADDRESS, HW_REGS_SIZE);
            a_idx_r    <= cap_addr_r[HW_REGS_SIZE-1:0];
            a_addr_r   <= cap_addr_r;
        end
    end

    // Stage B: the bank is sampled on the same edge the entry is pushed.
    always_comb begin
        push_data_s      = '0;
        push_data_s.addr = a_addr_r;
        push_data_s.hit  = a_hit_r;
        if (a_hit_r) begin
            push_data_s.data = regs[a_idx_r];
        end else begin
            push_data_s.data = MISS_DATA;
        end
    end

    // Outstanding-request credits bound the pipeline plus FIFO occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            cred_r <= '0;
        end else begin
            case ({accept_s, pop_s})
                2'b10:   cred_r <= cred_r + CW'(1);
                2'b01:   cred_r <= cred_r - CW'(1);
                default: cred_r <= cred_r;
            endcase
        end
    end

    hw_regs_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (a_vld_r),
        .push_data (push_data_s),
        .pop       (pop_s),
        .count     (fifo_count_s),
        .head      (head_s)
    );

    assign bus.rsp_valid = (fifo_count_s != '0);
    assign bus.rsp_data  = head_s.data;
    assign bus.rsp_hit   = head_s.hit;
    assign bus.rsp_addr  = head_s.addr;

endmodule

// File: tb/tb_gpu_hw_regs_read_port.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_gpu_hw_regs_read_port;
    import gpu_hw_regs_pkg::*;

    localparam int RS    = 8;
    localparam int NREG  = 256;
    localparam int DEPTH = 4;

    typedef struct {
        logic [19:0] addr;
        int          due;
    } pend_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREG-1:0][7:0]  regs;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    pend_t       pend_q[$];
    hw_reg_rsp_t exp_q[$];
    logic [7:0]  got_q[$];

    gpu_hw_regs_read_port_if bus();

    gpu_hw_regs_read_port #(
        .HW_REGS_SIZE (RS),
        .BASE_ADDRESS (20'h0),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .regs (regs),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a request accepted at edge N reads the bank as it stands at edge N+2.
    always @(posedge clk) begin
        hw_reg_rsp_t r;
        if (rst) begin
            pend_q.delete();
            exp_q.delete();
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                got_q.push_back(bus.rsp_data);
                if (exp_q.size() != 0) exp_q.delete(0);
            end
            while (pend_q.size() != 0 && pend_q[0].due == cyc) begin
                r.addr = pend_q[0].addr;
                r.hit  = (pend_q[0].addr[19:8] == 12'h000);
                r.data = r.hit ? regs[pend_q[0].addr[7:0]] : 8'hFF;
                exp_q.push_back(r);
                pend_q.delete(0);
            end
            if (bus.req_valid && bus.req_ready) pend_q.push_back('{bus.req_addr, cyc + 2});
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and compare the DUT against the model.
    task automatic step();
        @(negedge clk);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_q.size() != 0));
        check("req_ready", 32'(bus.req_ready),
              32'(!rst && ((pend_q.size() + exp_q.size()) < DEPTH)));
        if (bus.rsp_valid && exp_q.size() != 0)
            check("rsp_head", 32'({bus.rsp_data, bus.rsp_hit, bus.rsp_addr}), 32'(exp_q[0]));
    endtask

    task automatic directed_read(input logic [19:0] a, input logic [7:0] d, input logic h,
                                 input string tag);
        bus.rsp_ready = 1'b1;
        bus.req_addr  = a;
        bus.req_valid = 1'b1;
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        check({tag, "_lat1"}, 32'(bus.rsp_valid), 32'd0);
        step();
        check({tag, "_lat2"}, 32'(bus.rsp_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_rsp"}, 32'({bus.rsp_data, bus.rsp_hit, bus.rsp_addr}), 32'({d, h, a}));
        step();
    endtask

    initial begin
        int   k;
        logic rdy;

        for (int i = 0; i < NREG; i++) regs[i] = (i < 64) ? 8'(i + 1) : 8'h00;
        bus.req_valid = 1'b1;
        bus.req_addr  = 20'h00005;
        bus.rsp_ready = 1'b1;

        // Reset held three cycles with a request pending
        repeat (3) begin
            step();
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
            check("rst_rsp_hit", 32'(bus.rsp_hit), 32'd0);
            check("rst_rsp_addr", 32'(bus.rsp_addr), 32'd0);
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.req_ready), 32'd1);

        // Hit and miss reads with latency
        directed_read(20'h00005, 8'h06, 1'b1, "hit05");
        directed_read(20'h00040, 8'h00, 1'b1, "hit40");
        directed_read(20'h00105, 8'hFF, 1'b0, "miss105");

        // Back-pressure: only DEPTH requests accepted while responses are held
        bus.rsp_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            bus.req_addr  = 20'(k);
            bus.req_valid = 1'b1;
            rdy = bus.req_ready;
            step();
            if (rdy) k++;
        end
        check("bp_accepted", 32'(k), 32'd4);
        check("bp_ready_low", 32'(bus.req_ready), 32'd0);
        got_q.delete();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 40 && got_q.size() < 5; i++) begin
            rdy = bus.req_ready && bus.req_valid;
            step();
            if (rdy) bus.req_valid = 1'b0;
        end
        check("bp_count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            check("bp_order", 32'(got_q[i]), 32'(i + 1));

        // Coherency: bank write on the stage B edge of the first read
        got_q.delete();
        bus.req_addr  = 20'h00010;
        bus.req_valid = 1'b1;
        step();
        step();
        bus.req_valid = 1'b0;
        step();
        regs[16] = 8'hAA;
        repeat (4) step();
        check("coh_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("coh_old", 32'(got_q[0]), 32'h11);
            check("coh_new", 32'(got_q[1]), 32'hAA);
        end
        regs[16] = 8'h11;

        // Reset with requests both in the pipeline and queued
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr  = 20'(i + 8);
            bus.req_valid = 1'b1;
            step();
        end
        bus.req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        got_q.delete();
        repeat (6) begin
            step();
            check("flush_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("flush_cred_zero", 32'(bus.req_ready), 32'd1);
        end
        check("flush_no_rsp", 32'(got_q.size()), 32'd0);
        directed_read(20'h00000, 8'h01, 1'b1, "post_rst");

        // Random traffic with random bank writes and back-pressure
        for (int i = 0; i < 400; i++) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_addr  = ($urandom_range(0, 1) != 0) ? {12'h000, 8'($urandom)} : 20'($urandom);
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, NREG - 1)] = 8'($urandom);
            step();
        end

        // Drain
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 50 && (exp_q.size() + pend_q.size()) != 0; i++) step();
        step();
        check("drain_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("drain_req_ready", 32'(bus.req_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
